// File: rtl/riscv_pipe_pkg.sv
// Shared definitions for the pipelined RISC-V core's inter-stage registers:
// bundle widths, NOP/bubble constants used as reset values, and the slot
// control struct used by pipe_stage_reg / pipe_slot.
package riscv_pipe_pkg;

  localparam int XLEN    = 32;

  // Stage bundle widths (pc + instr, decoded operands, alu result, writeback)
  localparam int IFID_W  = 2 * XLEN;
  localparam int IDEX_W  = 4 * XLEN;
  localparam int EXMEM_W = 3 * XLEN;
  localparam int MEMWB_W = 2 * XLEN;

  // addi x0, x0, 0 : canonical RISC-V NOP, used as the bubble instruction
  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

  // Bubble bundles used as RESET_VAL per stage (instr field in the low word)
  localparam logic [IFID_W-1:0]  IFID_NOP  = {{(IFID_W-XLEN){1'b0}},  NOP_INSTR};
  localparam logic [IDEX_W-1:0]  IDEX_NOP  = {{(IDEX_W-XLEN){1'b0}},  NOP_INSTR};
  localparam logic [EXMEM_W-1:0] EXMEM_NOP = {{(EXMEM_W-XLEN){1'b0}}, NOP_INSTR};
  localparam logic [MEMWB_W-1:0] MEMWB_NOP = {{(MEMWB_W-XLEN){1'b0}}, NOP_INSTR};

  // Per-slot control: clear wins over load inside the slot
  typedef struct packed {
    logic load;
    logic clear;
  } slot_ctrl_t;

endpackage

// File: rtl/pipe_slot.sv
// One storage slot of a pipeline stage: WIDTH-bit data register plus valid
// bit. clear drops the valid bit and leaves the data untouched; load captures
// data_i and sets valid. Async reset puts data at RESET_VAL and valid at 0.
module pipe_slot
  import riscv_pipe_pkg::*;
#(
  parameter int               WIDTH     = 32,
  parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{1'b0}}
) (
  input  logic             clk,
  input  logic             rst_n,
  input  slot_ctrl_t       ctrl_i,
  input  logic [WIDTH-1:0] data_i,
  output logic             valid_o,
  output logic [WIDTH-1:0] data_o
);

  logic             valid_q, valid_d;
  logic [WIDTH-1:0] data_q,  data_d;

  // Next-state: clear has priority, data only changes on load
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (ctrl_i.clear) begin
      valid_d = 1'b0;
    end else if (ctrl_i.load) begin
      valid_d = 1'b1;
      data_d  = data_i;
    end else begin
      valid_d = valid_q;
    end
  end

  // Slot state registers with async reset to the bubble value
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q  <= RESET_VAL;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// Pipeline stage register with valid/ready handshake and flush.
// Build option: define PIPE_STAGE_SKID_EN for a 2-slot skid buffer with
// in_ready taken straight from a register (no out_ready->in_ready path);
// leave it undefined for a single slot with combinational in_ready.
// Flush clears every valid bit, discards a same-cycle in-accept and leaves
// the data registers alone.
module pipe_stage_reg
  import riscv_pipe_pkg::*;
#(
  parameter int               WIDTH     = 32,
  parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{1'b0}}
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
);

  logic             in_acc_s;
  logic             out_acc_s;
  logic             m_valid_s;
  logic [WIDTH-1:0] m_data_s;
  logic [WIDTH-1:0] m_din_s;
  slot_ctrl_t       m_ctrl_s;

  assign out_acc_s = m_valid_s && out_ready;
  assign in_acc_s  = in_valid && in_ready && !flush;

`ifdef PIPE_STAGE_SKID_EN
  logic             s_valid_s;
  logic [WIDTH-1:0] s_data_s;
  slot_ctrl_t       s_ctrl_s;

  assign in_ready = !s_valid_s;

  // Steering: fill M when empty/draining, park in S when M is stalled,
  // refill M from S as soon as M drains
  always_comb begin
    m_ctrl_s.load  = 1'b0;
    m_ctrl_s.clear = 1'b0;
    s_ctrl_s.load  = 1'b0;
    s_ctrl_s.clear = 1'b0;
    m_din_s        = in_data;
    if (flush) begin
      m_ctrl_s.clear = 1'b1;
      s_ctrl_s.clear = 1'b1;
    end else if (out_acc_s) begin
      if (s_valid_s) begin
        m_ctrl_s.load  = 1'b1;
        m_din_s        = s_data_s;
        s_ctrl_s.clear = 1'b1;
      end else if (in_acc_s) begin
        m_ctrl_s.load  = 1'b1;
      end else begin
        m_ctrl_s.clear = 1'b1;
      end
    end else if (in_acc_s) begin
      if (m_valid_s) begin
        s_ctrl_s.load = 1'b1;
      end else begin
        m_ctrl_s.load = 1'b1;
      end
    end else begin
      m_din_s = in_data;
    end
  end

  pipe_slot #(
    .WIDTH     (WIDTH),
    .RESET_VAL (RESET_VAL)
  ) u_slot_s (
    .clk     (clk),
    .rst_n   (rst_n),
    .ctrl_i  (s_ctrl_s),
    .data_i  (in_data),
    .valid_o (s_valid_s),
    .data_o  (s_data_s)
  );
`else
  assign in_ready = !m_valid_s || out_ready;

  // Steering: single slot, load on in-accept, clear on drain-only
  always_comb begin
    m_ctrl_s.load  = 1'b0;
    m_ctrl_s.clear = 1'b0;
    m_din_s        = in_data;
    if (flush) begin
      m_ctrl_s.clear = 1'b1;
    end else if (in_acc_s) begin
      m_ctrl_s.load  = 1'b1;
    end else if (out_acc_s) begin
      m_ctrl_s.clear = 1'b1;
    end else begin
      m_ctrl_s.load  = 1'b0;
    end
  end
`endif

  pipe_slot #(
    .WIDTH     (WIDTH),
    .RESET_VAL (RESET_VAL)
  ) u_slot_m (
    .clk     (clk),
    .rst_n   (rst_n),
    .ctrl_i  (m_ctrl_s),
    .data_i  (m_din_s),
    .valid_o (m_valid_s),
    .data_o  (m_data_s)
  );

  assign out_valid = m_valid_s;
  assign out_data  = m_data_s;

endmodule
